seq_detect_moore: RTL and testbench
===================================

SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011, target sequence; MSB is received first.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match-counter width, legal range 2..32.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port x_in, input, 1, serial data bit.
REQ-008 SHALL have port x_vld, input, 1, x_in is consumed only in cycles where x_vld=1.
REQ-009 SHALL have port clr, input, 1, synchronous clear of detector state and count.
REQ-010 SHALL have port y_out, output, 1, Moore match flag.
REQ-011 SHALL have port match_cnt, output, CNT_W, number of matches since reset or clr.
REQ-012 SHALL have port cnt_sat, output, 1, high while match_cnt is at its maximum value.

Function
REQ-013 State s SHALL range over 0..PAT_W and equal the length of the longest suffix of consumed bits that is also a prefix of PATTERN.
REQ-014 For s<PAT_W, a consumed bit x SHALL move s to the largest k<=PAT_W such that prefix(k) is a suffix of prefix(s) followed by x (KMP transition).
REQ-015 For s=PAT_W with OVERLAP=1, the next state SHALL be computed by the REQ-014 rule applied to the full pattern followed by x.
REQ-016 For s=PAT_W with OVERLAP=0, the next state SHALL be the REQ-014 transition taken from s=0.
REQ-017 With x_vld=0, s SHALL hold, including at s=PAT_W.
REQ-018 y_out SHALL be 1 exactly when s=PAT_W, decoded from state only (Moore), so it rises one clock after the completing bit is sampled.
REQ-019 match_cnt SHALL increment by 1 in every cycle where x_vld=1, clr=0 and the next state is PAT_W, including PAT_W->PAT_W transitions.
REQ-020 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap; cnt_sat=1 iff match_cnt=2^CNT_W-1.
REQ-021 clr=1 SHALL force s=0 and match_cnt=0 on the next edge, take priority over x_vld, and suppress any increment in that cycle.
REQ-022 Transition tables SHALL be derived at elaboration from PATTERN, with no runtime pattern loading.

Reset
REQ-023 rstn=0 SHALL immediately set s=0, y_out=0, match_cnt=0 and cnt_sat=0, regardless of clk.
REQ-024 Reset asserted mid-sequence SHALL discard all partial-match history; detection restarts from the first valid bit after rstn returns high.

Configuration
REQ-025 With macro SEQ_DET_CNT_EN defined, the match counter and saturation logic SHALL be built as specified.
REQ-026 Without SEQ_DET_CNT_EN, the counter SHALL not be instantiated; match_cnt and cnt_sat SHALL remain present and be tied to 0, and y_out behaviour SHALL be unchanged.

Structure
REQ-027 Shared package seq_det_pkg SHALL hold the state-width function (clog2 of PAT_W+1), the KMP next-state function and the saturating-max constant helper.
REQ-028 The counter SHALL be a sub-module named seq_det_sat_cnt (inputs clk, rstn, clr, inc; outputs cnt, sat), instantiated only under SEQ_DET_CNT_EN.

Verification
REQ-029 PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with x_vld=1 -> y_out high after bits 4 and 7, match_cnt=2.
REQ-030 Same stream with OVERLAP=0 -> y_out high only after bit 4, match_cnt=1.
REQ-031 PATTERN=1011, stream 1,0,(x_vld=0 for 3 cycles),1,1 -> state holds through the gap, y_out high after the final 1, match_cnt=1.
REQ-032 PATTERN=1111, OVERLAP=1, CNT_W=2, seven consecutive 1s -> y_out high from bit 4 onward, match_cnt reaches 3, cnt_sat=1, no wrap.
REQ-033 PATTERN=1011, bits 1,0,1 then rstn pulse low, then 1,1 -> y_out=0 and match_cnt=0 throughout; separately, clr=1 on the completing bit -> y_out stays 0 and match_cnt is not incremented.
REQ-034 Build without SEQ_DET_CNT_EN and rerun REQ-029 -> identical y_out trace, with match_cnt=0 and cnt_sat=0 constantly.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the Moore sequence detector: state width, KMP next-state
// function and saturating-max constant. All are evaluated at elaboration.
package seq_det_pkg;

    localparam int MAX_PAT_W = 16;

    function automatic int st_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic logic [31:0] sat_max(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    // Bit idx of the pattern, counted from the LSB.
    function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int idx);
        logic [MAX_PAT_W-1:0] tmp;
        tmp = pat >> idx;
        return tmp[0];
    endfunction

    // Longest prefix of the pattern that is a suffix of prefix(s) followed by x.
    // Prefix bit i (received i-th) is pat[pat_w-1-i].
    function automatic int kmp_next(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                    input int s, input logic x);
        int   len;
        int   best;
        int   j;
        logic ok;
        logic cb;
        len  = s + 1;
        best = 0;
        for (int k = 1; k <= MAX_PAT_W; k++) begin
            if (k <= pat_w && k <= len) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_W; i++) begin
                    if (i < k) begin
                        j = len - k + i;
                        if (j == s) cb = x;
                        else        cb = pat_bit(pat, pat_w - 1 - j);
                        if (cb != pat_bit(pat, pat_w - 1 - i)) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr)
            cnt_next = '0;
        else if (inc && (cnt_reg != CNT_MAX))
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign cnt = cnt_reg;
    assign sat = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with KMP transition tables built from PATTERN.
// Optional match counter is built only when SEQ_DET_CNT_EN is defined.
module seq_detect_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             x_in,
    input  logic             x_vld,
    input  logic             clr,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int              ST_W    = st_width(PAT_W);
    localparam int              NUM_ST  = 1 << ST_W;
    localparam logic [ST_W-1:0] ST_FULL = ST_W'(PAT_W);

    logic [ST_W-1:0] nxt0 [NUM_ST];
    logic [ST_W-1:0] nxt1 [NUM_ST];
    logic [ST_W-1:0] state_reg;
    logic [ST_W-1:0] state_next;

    // Unreachable encodings above PAT_W fall back to state 0's transitions.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ST; gi++) begin : g_tbl
            localparam int S   = (gi > PAT_W) ? 0 : gi;
            localparam int SRC = (S == PAT_W && OVERLAP == 0) ? 0 : S;
            localparam logic [ST_W-1:0] N0 =
                ST_W'(kmp_next(MAX_PAT_W'(PATTERN), PAT_W, SRC, 1'b0));
            localparam logic [ST_W-1:0] N1 =
                ST_W'(kmp_next(MAX_PAT_W'(PATTERN), PAT_W, SRC, 1'b1));
            assign nxt0[gi] = N0;
            assign nxt1[gi] = N1;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (clr)
            state_next = '0;
        else if (x_vld)
            state_next = x_in ? nxt1[state_reg] : nxt0[state_reg];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_reg <= '0;
        else
            state_reg <= state_next;
    end

    assign y_out = (state_reg == ST_FULL);

`ifdef SEQ_DET_CNT_EN
    logic inc;
    assign inc = x_vld && !clr && (state_next == ST_FULL);

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (inc),
        .cnt  (match_cnt),
        .sat  (cnt_sat)
    );
`else
    assign match_cnt = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed-vector bench for seq_detect_moore: 1011 overlapping and non-overlapping
// instances share one stimulus table; a 1111/CNT_W=2 instance covers saturation.
module tb_seq_detect_moore;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn, clr, x_in, x_vld, x1, v1;
    logic       y_ov, y_no, y_1;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_1;
    logic       s_ov, s_no, s_1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rstn(rstn), .x_in(x_in), .x_vld(x_vld), .clr(clr),
        .y_out(y_ov), .match_cnt(c_ov), .cnt_sat(s_ov));

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
        .clk(clk), .rstn(rstn), .x_in(x_in), .x_vld(x_vld), .clr(clr),
        .y_out(y_no), .match_cnt(c_no), .cnt_sat(s_no));

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) dut_ones (
        .clk(clk), .rstn(rstn), .x_in(x1), .x_vld(v1), .clr(clr),
        .y_out(y_1), .match_cnt(c_1), .cnt_sat(s_1));

    typedef struct {
        logic rstn;
        logic clr;
        logic vld;
        logic x;
        logic y_ov;
        logic y_no;
        int   c_ov;
        int   c_no;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c, input logic v, input logic x,
                       input logic yo, input logic yn, input int co, input int cn);
        vec_t t;
        t.rstn = r; t.clr = c; t.vld = v; t.x = x;
        t.y_ov = yo; t.y_no = yn; t.c_ov = co; t.c_no = cn;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ec(input int v);
        return CNT_EN ? v : 0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; clr = 1'b0; x_in = 1'b0; x_vld = 1'b0; x1 = 1'b0; v1 = 1'b0;

        //   rstn clr vld x   y_ov y_no c_ov c_no
        add(0, 0, 0, 0,   0, 0, 0, 0);   // reset
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);   // stream 1011011
        add(1, 0, 1, 0,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   1, 1, 1, 1);
        add(1, 0, 1, 0,   0, 0, 1, 1);
        add(1, 0, 1, 1,   0, 0, 1, 1);
        add(1, 0, 1, 1,   1, 0, 2, 1);
        add(1, 0, 0, 1,   1, 0, 2, 1);   // hold at full match
        add(1, 1, 0, 0,   0, 0, 0, 0);   // clr
        add(1, 0, 1, 1,   0, 0, 0, 0);   // 1,0,gap,1,1
        add(1, 0, 1, 0,   0, 0, 0, 0);
        add(1, 0, 0, 1,   0, 0, 0, 0);
        add(1, 0, 0, 1,   0, 0, 0, 0);
        add(1, 0, 0, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   1, 1, 1, 1);
        add(1, 0, 1, 1,   0, 0, 1, 1);   // clr on completing bit
        add(1, 0, 1, 0,   0, 0, 1, 1);
        add(1, 0, 1, 1,   0, 0, 1, 1);
        add(1, 1, 1, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);   // 1,0,1 then reset, then 1,1
        add(1, 0, 1, 0,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);
        add(0, 0, 1, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);
        add(1, 0, 1, 1,   0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rstn = tbl[i].rstn; clr = tbl[i].clr; x_vld = tbl[i].vld; x_in = tbl[i].x;
            @(posedge clk);
            #1;
            $display("vec %0d: rstn=%0b clr=%0b vld=%0b x=%0b -> y_ov=%0b y_no=%0b cnt_ov=%0d cnt_no=%0d",
                     i, rstn, clr, x_vld, x_in, y_ov, y_no, c_ov, c_no);
            check($sformatf("vec%0d y_ov", i), 32'(y_ov), 32'(tbl[i].y_ov));
            check($sformatf("vec%0d y_no", i), 32'(y_no), 32'(tbl[i].y_no));
            check($sformatf("vec%0d cnt_ov", i), 32'(c_ov), 32'(ec(tbl[i].c_ov)));
            check($sformatf("vec%0d cnt_no", i), 32'(c_no), 32'(ec(tbl[i].c_no)));
            check($sformatf("vec%0d sat_ov", i), 32'(s_ov), 32'd0);
        end

        // Both 1011 instances sit in state 1; finish the pattern, then assert
        // reset between clock edges and check it acts without an edge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x_vld = 1'b1; x_in = (i == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        $display("pre-reset: y_ov=%0b y_no=%0b cnt_ov=%0d", y_ov, y_no, c_ov);
        check("prerst y_ov", 32'(y_ov), 32'd1);
        check("prerst y_no", 32'(y_no), 32'd1);
        check("prerst cnt_ov", 32'(c_ov), 32'(ec(1)));
        #2;
        rstn = 1'b0;
        #1;
        $display("async reset: y_ov=%0b y_no=%0b cnt_ov=%0d", y_ov, y_no, c_ov);
        check("asyncrst y_ov", 32'(y_ov), 32'd0);
        check("asyncrst y_no", 32'(y_no), 32'd0);
        check("asyncrst cnt_ov", 32'(c_ov), 32'd0);
        @(negedge clk);
        rstn = 1'b1; x_vld = 1'b0;

        // Seven 1s into 1111 with a 2-bit counter: saturates at 3, no wrap.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x1 = 1'b1; v1 = (i < 7);
            @(posedge clk);
            #1;
            $display("ones %0d: vld=%0b -> y=%0b cnt=%0d sat=%0b", i, v1, y_1, c_1, s_1);
            check($sformatf("ones%0d y", i), 32'(y_1), (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("ones%0d cnt", i), 32'(c_1),
                  32'(ec((i < 3) ? 0 : (i > 5) ? 3 : i - 2)));
            check($sformatf("ones%0d sat", i), 32'(s_1), 32'(ec((i >= 5) ? 1 : 0)));
        end
        @(negedge clk);
        v1 = 1'b0; clr = 1'b1;
        @(posedge clk);
        #1;
        $display("ones clr: y=%0b cnt=%0d sat=%0b", y_1, c_1, s_1);
        check("ones clr y", 32'(y_1), 32'd0);
        check("ones clr cnt", 32'(c_1), 32'd0);
        check("ones clr sat", 32'(s_1), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
